// File: rtl/tron_ctrl_pkg.sv
// tron_ctrl_pkg: shared state codes, opcode/ext fields, bus/shift encodings and strobe bundle for the Tron controller (HALT state exists only with TRON_CTRL_HALT_EN)
package tron_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t FETCH   = 3'd0;
    localparam state_t DECODE  = 3'd1;
    localparam state_t EXECUTE = 3'd2;
    localparam state_t MEMWAIT = 3'd3;
    localparam state_t LOADWB  = 3'd4;
`ifdef TRON_CTRL_HALT_EN
    localparam state_t HALT    = 3'd5;
`endif

    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_SHIFT   = 4'b1000;
    localparam logic [3:0] OP_BCOND   = 4'b1100;
    localparam logic [3:0] OP_LUI     = 4'b1111;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_ASHU  = 4'b0110;
    localparam logic [3:0] EXT_WAIT  = 4'b0000;
    localparam logic [3:0] ALU_CMP   = 4'b1011;

    localparam logic [2:0] BUS_ALU   = 3'd0;
    localparam logic [2:0] BUS_SHIFT = 3'd1;
    localparam logic [2:0] BUS_MEM   = 3'd2;
    localparam logic [2:0] BUS_IMM   = 3'd3;
    localparam logic [2:0] BUS_PC1   = 3'd4;
    localparam logic [2:0] BUS_REGB  = 3'd5;

    localparam logic [1:0] SH_LSH   = 2'd0;
    localparam logic [1:0] SH_LSHI  = 2'd1;
    localparam logic [1:0] SH_ASHU  = 2'd2;
    localparam logic [1:0] SH_ASHUI = 2'd3;

    localparam logic [3:0] COND_UC = 4'b1110;

    typedef struct packed {
        logic       imm_mux;
        logic       lui_op;
        logic       reg_write;
        logic       mem_write;
        logic       flag_write;
        logic       pc_add;
        logic       pc_jump;
        logic       pc_branch;
        logic       addr_sel;
        logic [2:0] bus_op;
        logic [1:0] shift_op;
        logic [3:0] flag_op;
    } ctrl_t;

    // ALU operation codes shared by R-type ext field and I-type opcode field
    function automatic logic is_alu(input logic [3:0] code);
        return code inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111,
                            4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110};
    endfunction

endpackage

// File: rtl/tron_controller_if.sv
// tron_controller_if: controller <-> datapath/memory bundle; halted exists only with TRON_CTRL_HALT_EN
interface tron_controller_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
);
    logic [WIDTH-1:0]   memData;
    logic [7:0]         instructionOp;
    logic [7:0]         immediate;
    logic [REGBITS-1:0] regAddA;
    logic [REGBITS-1:0] regAddB;
    logic [3:0]         ALUOp;
    logic [1:0]         shiftOp;
    logic [2:0]         busOp;
    logic               immMUX;
    logic               LUIOp;
    logic               regWrite;
    logic               memWrite;
    logic               flagWrite;
    logic [3:0]         flagOp;
    logic               pcAdd;
    logic               pcJump;
    logic               pcBranch;
    logic               addrSel;
`ifdef TRON_CTRL_HALT_EN
    logic               halted;
`endif

    modport master (
        input  memData,
        output instructionOp, immediate, regAddA, regAddB, ALUOp, shiftOp, busOp,
               immMUX, LUIOp, regWrite, memWrite, flagWrite, flagOp,
               pcAdd, pcJump, pcBranch, addrSel
`ifdef TRON_CTRL_HALT_EN
        , output halted
`endif
    );

    modport slave (
        output memData,
        input  instructionOp, immediate, regAddA, regAddB, ALUOp, shiftOp, busOp,
               immMUX, LUIOp, regWrite, memWrite, flagWrite, flagOp,
               pcAdd, pcJump, pcBranch, addrSel
`ifdef TRON_CTRL_HALT_EN
        , input halted
`endif
    );

endinterface

// File: rtl/tron_decode.sv
// tron_decode: combinational IR+state to datapath strobes and post-EXECUTE state; WAIT->HALT only with TRON_CTRL_HALT_EN
module tron_decode
    import tron_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  state_t             state,
    input  logic [WIDTH-1:0]   ir,
    input  logic               kill,
    output ctrl_t              ctrl,
    output state_t             exec_next,
    output logic [7:0]         instr_op,
    output logic [7:0]         imm,
    output logic [REGBITS-1:0] reg_a,
    output logic [REGBITS-1:0] reg_b,
    output logic [3:0]         alu_op
);

    logic [3:0] op;
    logic [3:0] ext;
    logic       is_load;
    logic       is_wait;
    logic       shift_imm;
    logic       shift_ok;

    assign op        = ir[15:12];
    assign ext       = ir[7:4];
    assign instr_op  = {op, ext};
    assign imm       = ir[7:0];
    assign reg_a     = ir[REGBITS-1:0];
    assign reg_b     = ir[8 +: REGBITS];
    assign alu_op    = op == OP_RTYPE ? ext : op;
    assign is_load   = op == OP_SPECIAL && ext == EXT_LOAD;
    assign shift_imm = ext[3:2] == 2'b00;
    assign shift_ok  = shift_imm || ext == EXT_LSH || ext == EXT_ASHU;

`ifdef TRON_CTRL_HALT_EN
    assign is_wait   = op == OP_RTYPE && ext == EXT_WAIT;
    assign exec_next = is_load ? MEMWAIT : is_wait ? HALT : FETCH;
`else
    assign is_wait   = 1'b0;
    assign exec_next = is_load ? MEMWAIT : FETCH;
`endif

    // Moore strobes per state/instruction class; forced idle while reset is held
    always_comb begin
        ctrl = '0;
        if (state == EXECUTE) begin
            if (op == OP_RTYPE && is_alu(ext)) begin
                ctrl.bus_op     = BUS_ALU;
                ctrl.reg_write  = ext != ALU_CMP;
                ctrl.flag_write = 1'b1;
                ctrl.pc_add     = 1'b1;
            end else if (is_alu(op)) begin
                ctrl.imm_mux    = 1'b1;
                ctrl.bus_op     = BUS_ALU;
                ctrl.reg_write  = op != ALU_CMP;
                ctrl.flag_write = 1'b1;
                ctrl.pc_add     = 1'b1;
            end else if (op == OP_LUI) begin
                ctrl.imm_mux   = 1'b1;
                ctrl.lui_op    = 1'b1;
                ctrl.bus_op    = BUS_IMM;
                ctrl.reg_write = 1'b1;
                ctrl.pc_add    = 1'b1;
            end else if (op == OP_SHIFT && shift_ok) begin
                ctrl.bus_op    = BUS_SHIFT;
                ctrl.shift_op  = shift_imm ? (ext[1] ? SH_ASHUI : SH_LSHI) : (ext[1] ? SH_ASHU : SH_LSH);
                ctrl.imm_mux   = shift_imm;
                ctrl.reg_write = 1'b1;
                ctrl.pc_add    = 1'b1;
            end else if (is_load) begin
                ctrl.addr_sel = 1'b1;
            end else if (op == OP_SPECIAL && ext == EXT_STOR) begin
                ctrl.addr_sel  = 1'b1;
                ctrl.bus_op    = BUS_REGB;
                ctrl.mem_write = 1'b1;
                ctrl.pc_add    = 1'b1;
            end else if (op == OP_BCOND) begin
                ctrl.pc_branch = 1'b1;
                ctrl.flag_op   = ir[11:8];
            end else if (op == OP_SPECIAL && ext == EXT_JCOND) begin
                ctrl.pc_jump = 1'b1;
                ctrl.flag_op = ir[11:8];
            end else if (op == OP_SPECIAL && ext == EXT_JAL) begin
                ctrl.bus_op    = BUS_PC1;
                ctrl.reg_write = 1'b1;
                ctrl.pc_jump   = 1'b1;
                ctrl.flag_op   = COND_UC;
            end else begin
                ctrl.pc_add = !is_wait;
            end
        end else if (state == MEMWAIT) begin
            ctrl.addr_sel = 1'b1;
        end else if (state == LOADWB) begin
            ctrl.bus_op    = BUS_MEM;
            ctrl.reg_write = 1'b1;
            ctrl.pc_add    = 1'b1;
        end
        if (kill) ctrl = '0;
    end

endmodule

// File: rtl/tron_controller.sv
// tron_controller: multicycle Tron CPU control FSM holding state and IR; TRON_CTRL_HALT_EN adds WAIT->HALT and the halted output
module tron_controller
    import tron_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    tron_controller_if.master bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    state_t           exec_next;
    ctrl_t            ctrl;

    tron_decode #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_decode (
        .state     (state_q),
        .ir        (ir_q),
        .kill      (reset),
        .ctrl      (ctrl),
        .exec_next (exec_next),
        .instr_op  (bus.instructionOp),
        .imm       (bus.immediate),
        .reg_a     (bus.regAddA),
        .reg_b     (bus.regAddB),
        .alu_op    (bus.ALUOp)
    );

    assign bus.immMUX    = ctrl.imm_mux;
    assign bus.LUIOp     = ctrl.lui_op;
    assign bus.regWrite  = ctrl.reg_write;
    assign bus.memWrite  = ctrl.mem_write;
    assign bus.flagWrite = ctrl.flag_write;
    assign bus.pcAdd     = ctrl.pc_add;
    assign bus.pcJump    = ctrl.pc_jump;
    assign bus.pcBranch  = ctrl.pc_branch;
    assign bus.addrSel   = ctrl.addr_sel;
    assign bus.busOp     = ctrl.bus_op;
    assign bus.shiftOp   = ctrl.shift_op;
    assign bus.flagOp    = ctrl.flag_op;
`ifdef TRON_CTRL_HALT_EN
    assign bus.halted    = state_q == HALT;
`endif

    // Next state; IR captures the word read during FETCH, valid in DECODE
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                ir_d    = bus.memData;
                state_d = EXECUTE;
            end
            EXECUTE: state_d = exec_next;
            MEMWAIT: state_d = LOADWB;
`ifdef TRON_CTRL_HALT_EN
            HALT:    state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase
    end

    // State and instruction registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_tron_controller.sv
// tb_tron_controller: directed checks of the Tron controller strobe sequencing
module tb_tron_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    tron_controller_if #(.WIDTH(16), .REGBITS(4)) bus();

    tron_controller #(.WIDTH(16), .REGBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {immMUX, LUIOp, regWrite, memWrite, flagWrite, pcAdd, pcJump, pcBranch, addrSel}
    logic [8:0] strb;
    assign strb = {bus.immMUX, bus.LUIOp, bus.regWrite, bus.memWrite, bus.flagWrite,
                   bus.pcAdd, bus.pcJump, bus.pcBranch, bus.addrSel};

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starting in FETCH: present word and advance to its EXECUTE cycle
    task automatic to_exec(input logic [15:0] w);
        bus.memData = w;
        tick(2);
    endtask

    task automatic test_reset();
        bus.memData = 16'h0355;
        reset = 1'b1;
        tick(2);
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL reset_strb got %b want %b", strb, 9'b0); end
        tests++; if (bus.busOp !== 3'd0 || bus.flagOp !== 4'd0 || bus.shiftOp !== 2'd0) begin fails++; $display("FAIL reset_ops got %0d/%0d/%0d want 0/0/0", bus.busOp, bus.flagOp, bus.shiftOp); end
        reset = 1'b0;
        #1;
        tests++; if (bus.immediate !== 8'h00 || bus.instructionOp !== 8'h00) begin fails++; $display("FAIL reset_ir got %h/%h want 00/00", bus.immediate, bus.instructionOp); end
`ifdef TRON_CTRL_HALT_EN
        tests++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", bus.halted); end
`endif
    endtask

    task automatic test_add();
        bus.memData = 16'h0355;
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL add_fetch got %b want %b", strb, 9'b0); end
        tick(1);
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL add_decode got %b want %b", strb, 9'b0); end
        tick(1);
        tests++; if (strb !== 9'b001011000) begin fails++; $display("FAIL add_strb got %b want %b", strb, 9'b001011000); end
        tests++; if (bus.regAddB !== 4'd3 || bus.regAddA !== 4'd5) begin fails++; $display("FAIL add_regs got %0d/%0d want 3/5", bus.regAddB, bus.regAddA); end
        tests++; if (bus.ALUOp !== 4'd5 || bus.busOp !== 3'd0) begin fails++; $display("FAIL add_ops got %0d/%0d want 5/0", bus.ALUOp, bus.busOp); end
        tick(1);
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL add_after got %b want %b", strb, 9'b0); end
    endtask

    task automatic test_addi();
        to_exec(16'h52FF);
        tests++; if (strb !== 9'b101011000) begin fails++; $display("FAIL addi_strb got %b want %b", strb, 9'b101011000); end
        tests++; if (bus.immediate !== 8'hFF || bus.instructionOp !== 8'h5F) begin fails++; $display("FAIL addi_imm got %h/%h want ff/5f", bus.immediate, bus.instructionOp); end
        tests++; if (bus.ALUOp !== 4'd5 || bus.regAddB !== 4'd2) begin fails++; $display("FAIL addi_ops got %0d/%0d want 5/2", bus.ALUOp, bus.regAddB); end
        tick(1);
    endtask

    task automatic test_cmp();
        to_exec(16'h01B2);
        tests++; if (strb !== 9'b000011000) begin fails++; $display("FAIL cmp_strb got %b want %b", strb, 9'b000011000); end
        tests++; if (bus.ALUOp !== 4'hB) begin fails++; $display("FAIL cmp_aluop got %h want b", bus.ALUOp); end
        tick(1);
    endtask

    task automatic test_lui();
        to_exec(16'hF312);
        tests++; if (strb !== 9'b111001000) begin fails++; $display("FAIL lui_strb got %b want %b", strb, 9'b111001000); end
        tests++; if (bus.busOp !== 3'd3 || bus.immediate !== 8'h12) begin fails++; $display("FAIL lui_bus got %0d/%h want 3/12", bus.busOp, bus.immediate); end
        tick(1);
    endtask

    task automatic test_shift();
        to_exec(16'h8305);
        tests++; if (strb !== 9'b101001000) begin fails++; $display("FAIL lshi_strb got %b want %b", strb, 9'b101001000); end
        tests++; if (bus.busOp !== 3'd1 || bus.shiftOp !== 2'd1) begin fails++; $display("FAIL lshi_ops got %0d/%0d want 1/1", bus.busOp, bus.shiftOp); end
        tick(1);
        to_exec(16'h8561);
        tests++; if (strb !== 9'b001001000) begin fails++; $display("FAIL ashu_strb got %b want %b", strb, 9'b001001000); end
        tests++; if (bus.busOp !== 3'd1 || bus.shiftOp !== 2'd2) begin fails++; $display("FAIL ashu_ops got %0d/%0d want 1/2", bus.busOp, bus.shiftOp); end
        tick(1);
    endtask

    task automatic test_load();
        to_exec(16'h4104);
        tests++; if (strb !== 9'b000000001) begin fails++; $display("FAIL load_exec got %b want %b", strb, 9'b000000001); end
        tick(1);
        tests++; if (strb !== 9'b000000001) begin fails++; $display("FAIL load_memwait got %b want %b", strb, 9'b000000001); end
        tick(1);
        tests++; if (strb !== 9'b001001000 || bus.busOp !== 3'd2) begin fails++; $display("FAIL load_wb got %b/%0d want %b/2", strb, bus.busOp, 9'b001001000); end
        tests++; if (bus.regAddB !== 4'd1 || bus.regAddA !== 4'd4) begin fails++; $display("FAIL load_regs got %0d/%0d want 1/4", bus.regAddB, bus.regAddA); end
        tick(1);
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL load_fetch got %b want %b", strb, 9'b0); end
    endtask

    task automatic test_back_to_back();
        to_exec(16'h4244);
        tests++; if (strb !== 9'b000101001 || bus.busOp !== 3'd5) begin fails++; $display("FAIL stor_exec got %b/%0d want %b/5", strb, bus.busOp, 9'b000101001); end
        tick(1);
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL stor_after got %b want %b", strb, 9'b0); end
        to_exec(16'hC0FE);
        tests++; if (strb !== 9'b000000010 || bus.flagOp !== 4'h0) begin fails++; $display("FAIL beq_exec got %b/%h want %b/0", strb, bus.flagOp, 9'b000000010); end
        tick(1);
    endtask

    task automatic test_jump();
        to_exec(16'h41C3);
        tests++; if (strb !== 9'b000000100 || bus.flagOp !== 4'h1) begin fails++; $display("FAIL jcond_exec got %b/%h want %b/1", strb, bus.flagOp, 9'b000000100); end
        tick(1);
        to_exec(16'h4E87);
        tests++; if (strb !== 9'b001000100) begin fails++; $display("FAIL jal_strb got %b want %b", strb, 9'b001000100); end
        tests++; if (bus.busOp !== 3'd4 || bus.flagOp !== 4'hE) begin fails++; $display("FAIL jal_ops got %0d/%h want 4/e", bus.busOp, bus.flagOp); end
        tick(1);
    endtask

    task automatic test_nop();
        to_exec(16'h4F31);
        tests++; if (strb !== 9'b000001000 || bus.busOp !== 3'd0) begin fails++; $display("FAIL nop_exec got %b/%0d want %b/0", strb, bus.busOp, 9'b000001000); end
        tick(1);
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL nop_after got %b want %b", strb, 9'b0); end
    endtask

    task automatic test_reset_mid();
        to_exec(16'h0355);
        reset = 1'b1;
        #1;
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL rst_exec got %b want %b", strb, 9'b0); end
        tick(1);
        reset = 1'b0;
        #1;
        tests++; if (bus.immediate !== 8'h00 || strb !== 9'b0) begin fails++; $display("FAIL rst_exec_ir got %h/%b want 00/%b", bus.immediate, strb, 9'b0); end
        to_exec(16'h4104);
        tick(1);
        tests++; if (strb !== 9'b000000001) begin fails++; $display("FAIL rst_pre_memwait got %b want %b", strb, 9'b000000001); end
        reset = 1'b1;
        #1;
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL rst_memwait got %b want %b", strb, 9'b0); end
        bus.memData = 16'h0355;
        tick(1);
        reset = 1'b0;
        #1;
        tests++; if (strb !== 9'b0 || bus.immediate !== 8'h00 || bus.instructionOp !== 8'h00) begin fails++; $display("FAIL rst_fetch got %b/%h want %b/00", strb, bus.immediate, 9'b0); end
        tick(1);
        tests++; if (strb !== 9'b0) begin fails++; $display("FAIL rst_decode got %b want %b", strb, 9'b0); end
        tick(1);
        tests++; if (strb !== 9'b001011000) begin fails++; $display("FAIL rst_refetch got %b want %b", strb, 9'b001011000); end
        tick(1);
    endtask

    task automatic test_wait();
        to_exec(16'h0000);
`ifdef TRON_CTRL_HALT_EN
        tests++; if (strb !== 9'b0 || bus.halted !== 1'b0) begin fails++; $display("FAIL wait_exec got %b/%b want %b/0", strb, bus.halted, 9'b0); end
        tick(1);
        tests++; if (strb !== 9'b0 || bus.halted !== 1'b1) begin fails++; $display("FAIL halt_enter got %b/%b want %b/1", strb, bus.halted, 9'b0); end
        bus.memData = 16'h0355;
        tick(4);
        tests++; if (strb !== 9'b0 || bus.halted !== 1'b1) begin fails++; $display("FAIL halt_stay got %b/%b want %b/1", strb, bus.halted, 9'b0); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        tests++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL halt_exit got %b want 0", bus.halted); end
        to_exec(16'h0355);
        tests++; if (strb !== 9'b001011000) begin fails++; $display("FAIL halt_resume got %b want %b", strb, 9'b001011000); end
`else
        tests++; if (strb !== 9'b000001000) begin fails++; $display("FAIL wait_nop got %b want %b", strb, 9'b000001000); end
`endif
        tick(1);
    endtask

    initial begin
        bus.memData = 16'h0000;
        test_reset();
        test_add();
        test_addi();
        test_cmp();
        test_lui();
        test_shift();
        test_load();
        test_back_to_back();
        test_jump();
        test_nop();
        test_reset_mid();
        test_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tron_controller.md
Name: tron_controller

Overview:
- Multicycle control FSM driving the 16-bit Tron CPU datapath: fetches the instruction word, holds it in an instruction register, decodes it, and sequences every datapath control strobe.
- It is the producer of all datapath control inputs. Together with the datapath and a synchronous single-port memory, it forms the complete core.

Parameters:
- WIDTH, 16, instruction/data word width.
- REGBITS, 4, register-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- memData  in  WIDTH  memory read data (valid the cycle after address presented)
- instructionOp  out  8  {IR[15:12], IR[7:4]} to sign-extend
- immediate  out  8  IR[7:0]
- regAddA  out  REGBITS  IR[3:0] (Rsrc)
- regAddB  out  REGBITS  IR[11:8] (Rdest)
- ALUOp  out  4  IR[7:4] for R-type, IR[15:12] for I-type
- shiftOp  out  2  shifter op
- busOp  out  3  write-back source select
- immMUX  out  1  1 = immediate operand
- LUIOp  out  1  immediate shifted to upper byte
- regWrite, memWrite, flagWrite  out  1 each  write strobes
- flagOp  out  4  condition code IR[11:8]
- pcAdd, pcJump, pcBranch  out  1 each  PC update strobes
- addrSel  out  1  memory address mux: 0 = PC, 1 = regA

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset: state=FETCH, IR=16'h0000, every output strobe 0, addrSel=0. Reset mid-instruction aborts it with no write strobes on the reset cycle.
- States and transitions:
  - FETCH: addrSel=0, go to DECODE.
  - DECODE: IR<=memData, go to EXECUTE.
  - EXECUTE: see per-class rules below.
  - MEMWAIT: addrSel=1, go to LOADWB.
  - LOADWB: busOp=MEM, regWrite=1, pcAdd=1, go to FETCH.
- EXECUTE by instruction class:
  - R-type ALU (op 0000): immMUX=0, busOp=ALU, regWrite=1 (0 for CMP), flagWrite=1, pcAdd=1.
  - I-type ALU (op in {0001,0010,0011,0101,0110,0111,1001,1010,1011,1101,1110}): same, with immMUX=1.
  - LUI (op 1111): immMUX=1, LUIOp=1, busOp=IMM, regWrite=1, pcAdd=1.
  - Shift (op 1000): busOp=SHIFT, shiftOp from ext; immMUX=1 for LSHI/ASHUI; regWrite=1, pcAdd=1.
  - LOAD (0100/0000): addrSel=1, no strobes, go to MEMWAIT.
  - STOR (0100/0100): addrSel=1, busOp=REGB, memWrite=1, pcAdd=1.
  - Bcond (1100): pcBranch=1, flagOp=IR[11:8].
  - Jcond (0100/1100): pcJump=1, flagOp=IR[11:8].
  - JAL (0100/1000): busOp=PC1, regWrite=1, pcJump=1, flagOp=UC (always).
  - Any other encoding: NOP, pcAdd=1 only.
- Every class except LOAD returns to FETCH after EXECUTE.
- Exactly one PC strobe per instruction. No strobe is active outside its state; all strobes are Moore outputs decoded from state+IR.
- Latency: 3 cycles per instruction, 5 for LOAD.
- Flags written in EXECUTE are visible to the next instruction's EXECUTE.

Optional Feature:
- Macro TRON_CTRL_HALT_EN.
- Defined: encoding 0000/0000 (WAIT) enters HALT, with an added output halted=1. HALT asserts no strobes and is left only by reset.
- Undefined: WAIT decodes as NOP, the halted port is absent, and there is no HALT state.

Decomposition:
- Package tron_ctrl_pkg holds:
  - state enum;
  - opcode/ext constants;
  - busOp encodings ALU=0, SHIFT=1, MEM=2, IMM=3, PC1=4, REGB=5;
  - shiftOp encodings;
  - condition code UC=4'b1110.
- Sub-module tron_decode: purely combinational IR+state to strobes. The top module holds the state register and IR.

Test Plan:
- ADD R3,R5 (16'h0355), memData held: DECODE latches, EXECUTE shows regAddB=3, regAddA=5, ALUOp=5, immMUX=0, regWrite=1, flagWrite=1, pcAdd=1 for 1 cycle; next state FETCH.
- ADDI R2,#-1 (16'h52FF): EXECUTE immMUX=1, immediate=8'hFF, instructionOp=8'h5F, ALUOp=5.
- LOAD R1,[R4] (16'h4104): EXECUTE addrSel=1 with no strobes; MEMWAIT; LOADWB busOp=2, regWrite=1, pcAdd=1; 5 cycles total.
- STOR then BEQ (16'h4244 then 16'hC0FE): STOR asserts memWrite=1 and busOp=5 for exactly 1 cycle; BEQ asserts pcBranch=1 with flagOp=0, pcAdd=0.
- JAL R14,R7 (16'h4E87): EXECUTE busOp=4, regWrite=1, pcJump=1, flagOp=4'hE.
- Reset asserted during MEMWAIT: next cycle FETCH, IR=0, all strobes 0, no regWrite issued; with TRON_CTRL_HALT_EN, 16'h0000 drives halted=1 until reset.
